// File: rtl/gpu_pkg.sv
// Shared types and constants for the GPU rectangle-fill datapath.
// Holds screen defaults, the fill FSM state type and a constant-multiply helper.
package gpu_pkg;

  localparam int unsigned H_RES_DEF = 640;
  localparam int unsigned V_RES_DEF = 480;

  typedef logic [15:0] pixel_t;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StRun,
    StDone
  } fill_state_e;

  // Multiply by a constant as a sum of shifted copies; with k fixed this folds to shift-adds.
  function automatic logic [31:0] mul_const(input logic [31:0] y, input int unsigned k);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) acc = acc + (y << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gpu_rect_clip.sv
// Combinational clip of a fill rectangle against the screen.
// Produces exclusive end coordinates, the first row's base address and empty/clipped flags.
module gpu_rect_clip
  import gpu_pkg::*;
#(
  parameter int unsigned H_RES  = H_RES_DEF,
  parameter int unsigned V_RES  = V_RES_DEF,
  parameter int unsigned ADDR_W = 19
) (
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  input  logic [9:0]        w,
  input  logic [8:0]        h,
  output logic [10:0]       x_end,
  output logic [10:0]       y_end,
  output logic [ADDR_W-1:0] row_base,
  output logic              empty,
  output logic              clipped
);

  localparam logic [10:0] HLim = 11'(H_RES);
  localparam logic [10:0] VLim = 11'(V_RES);

  logic [10:0] x_sum;
  logic [10:0] y_sum;
  logic        off_screen;

  // 11-bit sums cannot wrap for 10/9-bit operands.
  assign x_sum = {1'b0, x} + {1'b0, w};
  assign y_sum = {2'b00, y} + {2'b00, h};

  assign x_end = (x_sum > HLim) ? HLim : x_sum;
  assign y_end = (y_sum > VLim) ? VLim : y_sum;

  assign off_screen = ({1'b0, x} >= HLim) || ({2'b00, y} >= VLim);
  assign empty      = off_screen || (w == 10'd0) || (h == 9'd0);
  assign clipped    = off_screen || (x_sum > HLim) || (y_sum > VLim);

  assign row_base = ADDR_W'(mul_const(32'(y), H_RES));

endmodule

// File: rtl/gpu_rect_fill.sv
// Rectangle fill engine: accepts a command, clips it once, then streams one pixel
// write per handshake in raster order using only incremental address arithmetic.
module gpu_rect_fill
  import gpu_pkg::*;
#(
  parameter int unsigned H_RES  = H_RES_DEF,
  parameter int unsigned V_RES  = V_RES_DEF,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_x,
  input  logic [8:0]        cmd_y,
  input  logic [9:0]        cmd_w,
  input  logic [8:0]        cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  input  logic              abort,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_last,
  output logic              busy,
  output logic              done,
  output logic              clipped
);

  localparam logic [ADDR_W-1:0] HStep = ADDR_W'(H_RES);

  fill_state_e state_q, state_d;

  logic [9:0]        cx_q;
  logic [8:0]        cy_q;
  logic [9:0]        cw_q;
  logic [8:0]        ch_q;
  logic [DATA_W-1:0] color_q;
  logic [10:0]       x_q, y_q;
  logic [10:0]       x_last_q, y_last_q;
  logic [ADDR_W-1:0] row_q, addr_q;
  logic              clipped_q;

  logic [10:0]       clip_x_end, clip_y_end;
  logic [ADDR_W-1:0] clip_row_base;
  logic              clip_empty, clip_clipped;
  logic              accept, xfer, is_last;

  gpu_rect_clip #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_clip (
    .x        (cx_q),
    .y        (cy_q),
    .w        (cw_q),
    .h        (ch_q),
    .x_end    (clip_x_end),
    .y_end    (clip_y_end),
    .row_base (clip_row_base),
    .empty    (clip_empty),
    .clipped  (clip_clipped)
  );

  // cmd_ready is gated by reset so it reads low while ARESET is held.
  assign cmd_ready = (state_q == StIdle) && !ARESET;
  assign accept    = cmd_valid && cmd_ready;
  assign pix_valid = (state_q == StRun);
  assign xfer      = pix_valid && pix_ready;
  assign is_last   = (x_q == x_last_q) && (y_q == y_last_q);
  assign pix_last  = pix_valid && is_last;
  assign pix_addr  = pix_valid ? addr_q : '0;
  assign pix_data  = pix_valid ? color_q : '0;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign clipped   = clipped_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StSetup;
      StSetup: begin
        if (abort)           state_d = StIdle;
        else if (clip_empty) state_d = StDone;
        else                 state_d = StRun;
      end
      // abort wins even when it coincides with the final handshake
      StRun: begin
        if (abort)                state_d = StIdle;
        else if (xfer && is_last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cx_q      <= '0;
      cy_q      <= '0;
      cw_q      <= '0;
      ch_q      <= '0;
      color_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      x_last_q  <= '0;
      y_last_q  <= '0;
      row_q     <= '0;
      addr_q    <= '0;
      clipped_q <= 1'b0;
    end else if (accept) begin
      cx_q    <= cmd_x;
      cy_q    <= cmd_y;
      cw_q    <= cmd_w;
      ch_q    <= cmd_h;
      color_q <= cmd_color;
    end else if (state_q == StSetup) begin
      x_q       <= {1'b0, cx_q};
      y_q       <= {2'b00, cy_q};
      x_last_q  <= clip_x_end - 11'd1;
      y_last_q  <= clip_y_end - 11'd1;
      row_q     <= clip_row_base;
      addr_q    <= clip_row_base + ADDR_W'(cx_q);
      clipped_q <= clip_clipped;
    end else if (xfer) begin
      if (x_q == x_last_q) begin
        x_q    <= {1'b0, cx_q};
        y_q    <= y_q + 11'd1;
        row_q  <= row_q + HStep;
        addr_q <= row_q + HStep + ADDR_W'(cx_q);
      end else begin
        x_q    <= x_q + 11'd1;
        addr_q <= addr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gpu_rect_fill.sv
// Self-checking bench for gpu_rect_fill: a pixel-list model built from the clip rules,
// a per-cycle compare process, directed cases and randomized commands with backpressure/abort.
module tb_gpu_rect_fill;

  localparam int H = 640;
  localparam int V = 480;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x = '0;
  logic [8:0]  cmd_y = '0;
  logic [9:0]  cmd_w = '0;
  logic [8:0]  cmd_h = '0;
  logic [15:0] cmd_color = '0;
  logic        abort = 1'b0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [18:0] pix_addr;
  logic [15:0] pix_data;
  logic        pix_last;
  logic        busy;
  logic        done;
  logic        clipped;

  gpu_rect_fill dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .abort     (abort),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_addr  (pix_addr),
    .pix_data  (pix_data),
    .pix_last  (pix_last),
    .busy      (busy),
    .done      (done),
    .clipped   (clipped)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [18:0] addr;
    logic [15:0] data;
    logic        last;
  } exp_pix_t;

  exp_pix_t exp_q[$];
  bit exp_active = 1'b0;
  bit chk_en = 1'b0;
  int checks = 0;
  int failures = 0;
  int xfer_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit model_clipped(input int x, input int y, input int w, input int h);
    return (x >= H) || (y >= V) || (x + w > H) || (y + h > V);
  endfunction

  function automatic int model_npix(input int x, input int y, input int w, input int h);
    int xe, ye;
    xe = (x + w > H) ? H : x + w;
    ye = (y + h > V) ? V : y + h;
    if (xe <= x || ye <= y) return 0;
    return (xe - x) * (ye - y);
  endfunction

  // Expected write list: every on-screen pixel of the rectangle in raster order.
  task automatic build_model(input int x, input int y, input int w, input int h,
                             input logic [15:0] c);
    int xe, ye;
    exp_pix_t p;
    xe = (x + w > H) ? H : x + w;
    ye = (y + h > V) ? V : y + h;
    exp_q.delete();
    for (int yy = y; yy < ye; yy++) begin
      for (int xx = x; xx < xe; xx++) begin
        p.addr = 19'(yy * H + xx);
        p.data = c;
        p.last = (yy == ye - 1) && (xx == xe - 1);
        exp_q.push_back(p);
      end
    end
  endtask

  always @(negedge ACLK) begin
    if (chk_en && !ARESET) begin
      chk("pix_valid", 32'(pix_valid), 32'(exp_active && exp_q.size() > 0));
      if (pix_valid && exp_q.size() > 0) begin
        chk("pix_addr", 32'(pix_addr), 32'(exp_q[0].addr));
        chk("pix_data", 32'(pix_data), 32'(exp_q[0].data));
        chk("pix_last", 32'(pix_last), 32'(exp_q[0].last));
        if (pix_ready) begin
          void'(exp_q.pop_front());
          xfer_cnt++;
        end
      end
    end
  end

  task automatic run_cmd(input int x, input int y, input int w, input int h,
                         input logic [15:0] c, input int rmode, input int abort_at);
    int cyc;
    bit aborted;
    bit exp_clip;
    aborted  = 1'b0;
    exp_clip = model_clipped(x, y, w, h);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    build_model(x, y, w, h, c);
    xfer_cnt  = 0;
    cmd_x     = 10'(x);
    cmd_y     = 9'(y);
    cmd_w     = 10'(w);
    cmd_h     = 9'(h);
    cmd_color = c;
    cmd_valid = 1'b1;
    pix_ready = 1'b1;
    @(posedge ACLK); #1;
    // Scramble the held fields so the DUT must use its registered copy.
    cmd_x     = 10'($urandom);
    cmd_y     = 9'($urandom);
    cmd_w     = 10'($urandom);
    cmd_h     = 9'($urandom);
    cmd_color = 16'($urandom);
    cmd_valid = (rmode != 0);
    @(negedge ACLK); #1;
    chk("setup_busy", 32'(busy), 32'd1);
    chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("setup_done", 32'(done), 32'd0);
    exp_active = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20000 && !aborted) begin
      @(posedge ACLK); #1;
      pix_ready = (rmode != 0) ? ($urandom % 3 != 0) : 1'b1;
      cmd_valid = (rmode != 0) ? 1'($urandom % 2) : 1'b0;
      if (abort_at >= 0 && xfer_cnt == abort_at) begin
        abort     = 1'b1;
        aborted   = 1'b1;
        cmd_valid = 1'b0;
      end
      @(negedge ACLK); #1;
      cyc++;
    end
    if (cyc >= 20000) begin
      checks++;
      failures++;
      $display("FAIL fill_timeout actual=%0d pending required=0", exp_q.size());
    end
    @(posedge ACLK); #1;
    cmd_valid  = 1'b0;
    abort      = 1'b0;
    exp_active = 1'b0;
    if (aborted) begin
      exp_q.delete();
      @(negedge ACLK); #1;
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
      @(negedge ACLK); #1;
      chk("abort_no_late_done", 32'(done), 32'd0);
    end else begin
      @(negedge ACLK); #1;
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd1);
      chk("done_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge ACLK); #1;
      chk("after_done", 32'(done), 32'd0);
      chk("after_busy", 32'(busy), 32'd0);
      chk("after_cmd_ready", 32'(cmd_ready), 32'd1);
    end
    chk("clipped", 32'(clipped), 32'(exp_clip));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_pix_last"}, 32'(pix_last), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_clipped"}, 32'(clipped), 32'd0);
    chk({tag, "_pix_addr"}, 32'(pix_addr), 32'd0);
    chk({tag, "_pix_data"}, 32'(pix_data), 32'd0);
  endtask

  initial begin
    int basic_addr[6];
    int x, y, w, h, n, ab;
    basic_addr = '{1922, 1923, 1924, 2562, 2563, 2564};

    #1 ARESET = 1'b1;
    #2;
    chk_reset_outputs("reset");
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    chk("release_cmd_ready", 32'(cmd_ready), 32'd1);
    chk_en = 1'b1;

    // Pin the model against hand-computed values.
    build_model(2, 3, 3, 2, 16'hF800);
    chk("model_basic_len", 32'(exp_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk("model_basic_addr", 32'(exp_q[i].addr), 32'(basic_addr[i]));
    chk("model_basic_last", 32'(exp_q[5].last), 32'd1);
    build_model(638, 479, 5, 4, 16'h07E0);
    chk("model_clip_len", 32'(exp_q.size()), 32'd2);
    chk("model_clip_a0", 32'(exp_q[0].addr), 32'd307198);
    chk("model_clip_a1", 32'(exp_q[1].addr), 32'd307199);
    chk("model_clip_flag", 32'(model_clipped(638, 479, 5, 4)), 32'd1);
    chk("model_empty_x_flag", 32'(model_clipped(700, 10, 4, 4)), 32'd1);
    chk("model_empty_w_flag", 32'(model_clipped(10, 10, 0, 4)), 32'd0);
    exp_q.delete();

    @(posedge ACLK); #1;
    run_cmd(2, 3, 3, 2, 16'hF800, 0, -1);
    run_cmd(638, 479, 5, 4, 16'h07E0, 0, -1);
    run_cmd(700, 10, 4, 4, 16'h001F, 0, -1);
    run_cmd(10, 10, 0, 4, 16'h1234, 0, -1);
    run_cmd(2, 3, 3, 2, 16'hF800, 1, -1);
    run_cmd(5, 5, 10, 10, 16'hABCD, 0, 3);
    run_cmd(2, 3, 3, 2, 16'hF800, 0, -1);

    // Reset in the middle of a clipped fill.
    build_model(600, 0, 100, 10, 16'h5555);
    cmd_x = 10'd600; cmd_y = 9'd0; cmd_w = 10'd100; cmd_h = 9'd10;
    cmd_color = 16'h5555; cmd_valid = 1'b1; pix_ready = 1'b1;
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
    @(negedge ACLK); #1;
    exp_active = 1'b1;
    repeat (5) @(negedge ACLK);
    #1;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    chk("pre_reset_clipped", 32'(clipped), 32'd1);
    @(posedge ACLK); #3;
    ARESET = 1'b1;
    #1;
    chk_reset_outputs("midrun_reset");
    exp_q.delete();
    exp_active = 1'b0;
    @(negedge ACLK); #2;
    ARESET = 1'b0;
    #1;
    chk("midrun_release_ready", 32'(cmd_ready), 32'd1);
    chk("midrun_release_busy", 32'(busy), 32'd0);
    repeat (3) begin
      @(negedge ACLK); #1;
      chk("midrun_no_done", 32'(done), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      x = ($urandom % 4 == 0) ? int'($urandom_range(600, 720)) : int'($urandom_range(0, 639));
      y = ($urandom % 4 == 0) ? int'($urandom_range(470, 511)) : int'($urandom_range(0, 479));
      w = (x >= 600 && $urandom % 2 == 0) ? int'($urandom_range(0, 1023))
                                           : int'($urandom_range(0, 12));
      h = (y >= 470) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 6));
      n = model_npix(x, y, w, h);
      ab = (n > 0 && $urandom % 5 == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_cmd(x, y, w, h, 16'($urandom), int'($urandom % 2), ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
